// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, filters the synchronized lock, and releases the core reset.
// Optional feature macro PLL_SEQ_TIMEOUT_EN enables the WAIT_LOCK timeout, retry and retry_cnt.
module pll_reset_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILTER  = 1024,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_cnt
);

  localparam int MAX_RF = (RST_CYCLES > LOCK_FILTER) ? RST_CYCLES : LOCK_FILTER;
`ifdef PLL_SEQ_TIMEOUT_EN
  localparam int MAX_P = (MAX_RF > LOCK_TIMEOUT) ? MAX_RF : LOCK_TIMEOUT;
`else
  localparam int MAX_P = MAX_RF;
`endif
  localparam int CW = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);

  typedef enum logic [1:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_FILTER,
    S_RUN
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          sync1_reg, lock_s;
  logic          lock_lost_next;

`ifdef PLL_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);
  logic [3:0] retry_reg, retry_next;
  assign retry_cnt = retry_reg;
`else
  // Timeout is compiled out; the parameter is kept for a uniform interface.
  logic unused_timeout;
  assign unused_timeout = ^LOCK_TIMEOUT;
  assign retry_cnt = 4'd0;
`endif

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_RESET;
      cnt_reg   <= '0;
      sync1_reg <= 1'b0;
      lock_s    <= 1'b0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
      retry_reg <= 4'd0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sync1_reg <= pll_locked;
      lock_s    <= sync1_reg;
      // Outputs decode the next state so they move on the same edge as the state.
      pll_rst   <= (state_next == S_RESET);
      sys_rst_n <= (state_next == S_RUN);
      ready     <= (state_next == S_RUN);
      lock_lost <= lock_lost_next;
`ifdef PLL_SEQ_TIMEOUT_EN
      retry_reg <= retry_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    lock_lost_next = 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
    retry_next     = retry_reg;
`endif
    case (state_reg)
      S_RESET: begin
        if (force_relock) begin
          cnt_next = '0;
        end else if (cnt_reg == RST_LAST) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (force_relock) begin
          state_next = S_RESET;
          cnt_next   = '0;
        end else if (lock_s) begin
          state_next = S_FILTER;
          cnt_next   = '0;
        end
`ifdef PLL_SEQ_TIMEOUT_EN
        else if (cnt_reg == TO_LAST) begin
          state_next = S_RESET;
          cnt_next   = '0;
          if (retry_reg != 4'hF) begin
            retry_next = retry_reg + 4'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      S_FILTER: begin
        if (force_relock) begin
          state_next = S_RESET;
          cnt_next   = '0;
        end else if (!lock_s) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == FILT_LAST) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_RUN: begin
        // A lock drop takes precedence so a coincident relock request still reports it.
        if (!lock_s) begin
          lock_lost_next = 1'b1;
          state_next     = S_RESET;
          cnt_next       = '0;
        end else if (force_relock) begin
          state_next = S_RESET;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_RESET;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer; expectations are queued per edge and popped after each edge.
// Timeout/retry section runs when PLL_SEQ_TIMEOUT_EN is defined, the indefinite-wait section otherwise.
module tb_pll_reset_sequencer;

  localparam int RC = 4;
  localparam int LF = 8;
  localparam int LT = 32;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  pll_reset_sequencer #(
    .RST_CYCLES  (RC),
    .LOCK_FILTER (LF),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .force_relock(force_relock),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .retry_cnt   (retry_cnt)
  );

  always #10 refclk = ~refclk;

  // {retry_cnt, lock_lost, ready, sys_rst_n, pll_rst}
  function automatic logic [7:0] pk(input logic [3:0] r, input logic ll, input logic rdy,
                                    input logic srn, input logic pr);
    return {r, ll, rdy, srn, pr};
  endfunction

  function automatic logic [7:0] outs();
    return {retry_cnt, lock_lost, ready, sys_rst_n, pll_rst};
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic compare_next();
    exp_t       e;
    logic [7:0] obs;
    e   = sb.pop_front();
    obs = outs();
    n_cmp++;
    assert (obs === e.exp) else begin
      n_err++;
      $error("FAIL %s observed=%02h expected=%02h (retry,lost,ready,sys_rst_n,pll_rst)",
             e.tag, obs, e.exp);
    end
  endtask

  task automatic expect_edges(input string tag, input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) begin
      push_exp(tag, v);
      tick();
      compare_next();
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    tick();
    tick();
    push_exp("reset_values", pk(0, 0, 0, 0, 1));
    compare_next();
    rst_n = 1'b1;

    // Power-up: pll_rst high for exactly RC edges, release LF+3 edges after lock
    expect_edges("pwr_pll_rst_hi", RC - 1, pk(0, 0, 0, 0, 1));
    expect_edges("pwr_pll_rst_fall", 1, pk(0, 0, 0, 0, 0));
    expect_edges("pwr_wait", 10, pk(0, 0, 0, 0, 0));
    pll_locked = 1'b1;
    expect_edges("pwr_filter", LF + 2, pk(0, 0, 0, 0, 0));
    expect_edges("pwr_release", 1, pk(0, 0, 1, 1, 0));

    // Lock loss in RUN
    pll_locked = 1'b0;
    expect_edges("loss_sync", 2, pk(0, 0, 1, 1, 0));
    expect_edges("loss_pulse", 1, pk(0, 1, 0, 0, 1));
    expect_edges("loss_rst", RC - 1, pk(0, 0, 0, 0, 1));
    expect_edges("loss_rst_fall", 1, pk(0, 0, 0, 0, 0));
    pll_locked = 1'b1;
    expect_edges("relock_filter", LF + 2, pk(0, 0, 0, 0, 0));
    expect_edges("relock_run", 1, pk(0, 0, 1, 1, 0));

    // force_relock alone: no pulse, reset on next edge, lock still held
    force_relock = 1'b1;
    expect_edges("force_edge", 1, pk(0, 0, 0, 0, 1));
    force_relock = 1'b0;
    expect_edges("force_rst", RC - 1, pk(0, 0, 0, 0, 1));
    expect_edges("force_rst_fall", 1, pk(0, 0, 0, 0, 0));
    expect_edges("force_filter", LF, pk(0, 0, 0, 0, 0));
    expect_edges("force_run", 1, pk(0, 0, 1, 1, 0));

    // force_relock coincident with the synchronized lock drop: one pulse
    pll_locked = 1'b0;
    expect_edges("both_sync", 2, pk(0, 0, 1, 1, 0));
    force_relock = 1'b1;
    expect_edges("both_pulse", 1, pk(0, 1, 0, 0, 1));
    force_relock = 1'b0;
    expect_edges("both_rst", RC - 1, pk(0, 0, 0, 0, 1));
    expect_edges("both_rst_fall", 1, pk(0, 0, 0, 0, 0));

    // Glitchy lock: 5 high, 1 low, then stable
    pll_locked = 1'b1;
    expect_edges("glitch_hi", 5, pk(0, 0, 0, 0, 0));
    pll_locked = 1'b0;
    expect_edges("glitch_lo", 1, pk(0, 0, 0, 0, 0));
    pll_locked = 1'b1;
    expect_edges("glitch_filter", LF + 2, pk(0, 0, 0, 0, 0));
    expect_edges("glitch_run", 1, pk(0, 0, 1, 1, 0));

    // Async reset while in FILTER
    force_relock = 1'b1;
    expect_edges("pre_ar_force", 1, pk(0, 0, 0, 0, 1));
    force_relock = 1'b0;
    expect_edges("pre_ar_rst", RC - 1, pk(0, 0, 0, 0, 1));
    expect_edges("pre_ar_wait", 1, pk(0, 0, 0, 0, 0));
    expect_edges("pre_ar_filter", 3, pk(0, 0, 0, 0, 0));
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    #2;
    push_exp("async_reset", pk(0, 0, 0, 0, 1));
    compare_next();
    tick();
    rst_n = 1'b1;

`ifdef PLL_SEQ_TIMEOUT_EN
    expect_edges("to_rst_hi", RC - 1, pk(0, 0, 0, 0, 1));
    expect_edges("to_rst_fall", 1, pk(0, 0, 0, 0, 0));
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] r_prev;
      logic [3:0] r_now;
      r_prev = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
      r_now  = (k > 15) ? 4'd15 : 4'(k);
      expect_edges("to_wait", LT - 1, pk(r_prev, 0, 0, 0, 0));
      expect_edges("to_retry", 1, pk(r_now, 0, 0, 0, 1));
      expect_edges("to_rst_hi", RC - 1, pk(r_now, 0, 0, 0, 1));
      expect_edges("to_rst_fall", 1, pk(r_now, 0, 0, 0, 0));
    end
    // Lock arrives on the timeout edge: lock wins
    expect_edges("tie_wait", LT - 3, pk(15, 0, 0, 0, 0));
    pll_locked = 1'b1;
    expect_edges("tie_sync", 2, pk(15, 0, 0, 0, 0));
    expect_edges("tie_lock_wins", 1, pk(15, 0, 0, 0, 0));
    expect_edges("tie_filter", LF - 1, pk(15, 0, 0, 0, 0));
    expect_edges("tie_run", 1, pk(15, 0, 1, 1, 0));
`else
    expect_edges("nto_rst_hi", RC - 1, pk(0, 0, 0, 0, 1));
    expect_edges("nto_rst_fall", 1, pk(0, 0, 0, 0, 0));
    expect_edges("nto_wait", 200 - RC, pk(0, 0, 0, 0, 0));
    pll_locked = 1'b1;
    expect_edges("nto_filter", LF + 2, pk(0, 0, 0, 0, 0));
    expect_edges("nto_run", 1, pk(0, 0, 1, 1, 0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequencer for the system PLL that generates the 11 MHz and 44 MHz core clocks from the 50 MHz reference. It runs on the reference clock, sequences the PLL reset, and qualifies the PLL lock output with a stability filter. It releases the core reset only after lock is stable, and re-runs the sequence whenever lock is lost or a relock is requested. It sits between the board reset input and the PLL instance, and drives the core-wide reset.

## Interface
Parameters:
- RST_CYCLES, 16: refclk cycles `pll_rst` is held high per attempt (≥2).
- LOCK_FILTER, 1024: consecutive synchronized-locked cycles required before release (≥1).
- LOCK_TIMEOUT, 65536: refclk cycles to wait for lock before retrying (≥4).

Ports:
- `refclk` in 1: 50 MHz reference clock; the only clock.
- `rst_n` in 1: asynchronous active-low reset.
- `pll_locked` in 1: PLL lock, asynchronous to `refclk`; passes through a 2-flop synchronizer.
- `force_relock` in 1: synchronous, level-sampled relock request.
- `pll_rst` out 1: active-high PLL reset.
- `sys_rst_n` out 1: active-low core reset; high only in RUN.
- `ready` out 1: high in RUN.
- `lock_lost` out 1: one-cycle pulse when lock drops in RUN.
- `retry_cnt` out 4: saturating count of lock timeouts.

## Operation
- States: RESET, WAIT_LOCK, FILTER, RUN. One shared counter, sized `$clog2` of the largest parameter, plus 1.
- Reset values (`rst_n` low): state RESET, counter 0, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `lock_lost`=0, `retry_cnt`=0, synchronizer flops 0.
- **RESET**: `pll_rst`=1. Count RST_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
- **WAIT_LOCK**: `pll_rst`=0.
  - If `lock_s`=1, go to FILTER with the counter cleared.
  - Otherwise, when the counter reaches LOCK_TIMEOUT−1, go to RESET and increment `retry_cnt`, saturating at 15.
  - If the timeout and `lock_s`=1 occur in the same cycle, lock wins.
- **FILTER**: count while `lock_s`=1. Any `lock_s`=0 returns to WAIT_LOCK with the counter cleared; `retry_cnt` is unchanged. After LOCK_FILTER consecutive high cycles, go to RUN.
- **RUN**: `sys_rst_n`=1, `ready`=1.
  - `lock_s`=0 → pulse `lock_lost`, go to RESET.
  - `force_relock`=1 → go to RESET, no pulse.
  - Both in the same cycle → pulse `lock_lost`, go to RESET.
- `force_relock`=1 in RESET, WAIT_LOCK or FILTER restarts RESET with the counter cleared; `retry_cnt` is unchanged.
- `retry_cnt` is cleared only by `rst_n`.

## Timing
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- `pll_rst` is high for exactly RST_CYCLES refclk cycles after `rst_n` deasserts: it falls on edge RST_CYCLES, counting the first post-reset edge as edge 1.
- `pll_locked` rise → `lock_s` high 2 edges later → FILTER entered on edge 3.
  - `sys_rst_n` and `ready` rise on edge LOCK_FILTER+3, counted from the first edge that samples `pll_locked`=1.
- Lock drop in RUN:
  - `sys_rst_n`/`ready` fall and `pll_rst` rises on the 3rd edge after the first edge that samples `pll_locked`=0.
  - `lock_lost` is high for that one cycle.
- `force_relock` in RUN → `sys_rst_n` low and `pll_rst` high on the next edge.
- `rst_n` assertion mid-operation forces all outputs to their reset values immediately (asynchronous). Deassertion restarts the sequence from RESET.

## Configuration
- `PLL_SEQ_TIMEOUT_EN` defined: WAIT_LOCK timeout and retry are implemented as described.
- `PLL_SEQ_TIMEOUT_EN` undefined:
  - WAIT_LOCK waits indefinitely for lock.
  - `retry_cnt` is tied to 0.
  - LOCK_TIMEOUT is ignored and does not affect counter width.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=32, macro defined unless noted.
- **Power-up:** release `rst_n`; `pll_locked` rises 10 cycles after `pll_rst` falls → `pll_rst` high for exactly 4 cycles; `sys_rst_n`/`ready` rise 11 edges after first locked sample; `retry_cnt`=0.
- **Glitchy lock:** `pll_locked` high 5 cycles, low 1, high again → no release at the first attempt; release 11 edges after the second rise; `retry_cnt`=0.
- **Timeout:** `pll_locked` held 0 → `pll_rst` re-pulses (4 cycles) every 36 cycles; `retry_cnt` counts 1,2,… and saturates at 15 after 15 timeouts.
- **Lock loss:** in RUN, drop `pll_locked` → `lock_lost` pulses exactly once on the 3rd edge; `pll_rst` high for 4 cycles; RUN reached again after relock.
- **Simultaneous events:** in RUN, `force_relock` alone → no pulse, `sys_rst_n` low next edge; `force_relock` and lock drop together → a single `lock_lost` pulse; `rst_n` asserted in FILTER → all outputs at reset values immediately.
- **Macro undefined:** `pll_locked` held 0 for 200 cycles → single `pll_rst` pulse; `retry_cnt` stays 0; late lock → normal release.
